// File: rtl/vga_capture_if.sv
// Pin bundle of the VGA capture block: incoming pixel stream and arm request,
// picture-RAM write port and capture status.
interface vga_capture_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned PW = 10,
    parameter int unsigned LW = 9
);
    logic          arm;
    logic          vga_hsync;
    logic          vga_vsync;
    logic          vga_valid;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;

    modport master (
        output arm, vga_hsync, vga_vsync, vga_valid, vga_r, vga_g, vga_b,
        input  wr_en, wr_addr, wr_data, busy, done, err, pix_cnt, line_cnt
    );

    modport slave (
        input  arm, vga_hsync, vga_vsync, vga_valid, vga_r, vga_g, vga_b,
        output wr_en, wr_addr, wr_data, busy, done, err, pix_cnt, line_cnt
    );
endinterface

// File: rtl/vga_capture.sv
// VGA stream capture: rebuilds pixel coordinates from sync/blank, writes one
// window of one frame into a picture RAM and checks the frame geometry.
module vga_capture #(
    parameter int unsigned HSIZE = 640,
    parameter int unsigned VSIZE = 480,
    parameter int unsigned WIN_X = 270,
    parameter int unsigned WIN_Y = 190,
    parameter int unsigned WIN_W = 100,
    parameter int unsigned WIN_H = 100,
    parameter int unsigned AW    = $clog2(WIN_W*WIN_H)
) (
    input  logic         clk,
    input  logic         rst,
    vga_capture_if.slave bus
);
    localparam int unsigned   PW    = $clog2(HSIZE+1);
    localparam int unsigned   LW    = $clog2(VSIZE+1);
    localparam logic [PW-1:0] X_LO  = PW'(WIN_X);
    localparam logic [PW-1:0] X_HI  = PW'(WIN_X + WIN_W);
    localparam logic [LW-1:0] Y_LO  = LW'(WIN_Y);
    localparam logic [LW-1:0] Y_HI  = LW'(WIN_Y + WIN_H);
    localparam logic [PW-1:0] H_EXP = PW'(HSIZE);
    localparam logic [LW-1:0] V_EXP = LW'(VSIZE);
    localparam logic [AW-1:0] NPIX  = AW'(WIN_W*WIN_H);

    typedef enum logic [1:0] {IDLE, ARMED, FRAME} state_e;
    state_e state_q, state_d;

    logic          s1_hs_q, s1_vs_q, s1_va_q, s2_vs_q, s2_va_q;
    logic [23:0]   s1_rgb_q;
    logic [PW-1:0] x_q, x_d, pix_q, pix_d;
    logic [LW-1:0] y_q, y_d, line_q, line_d;
    logic [AW-1:0] wcnt_q, wcnt_d, wr_addr_q, wr_addr_d;
    logic [23:0]   wr_data_q, wr_data_d;
    logic          wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
    logic          vs_fall, va_fall, in_win, wr_req;
    logic          arm_take, in_frame, busy;

    assign vs_fall = s2_vs_q & ~s1_vs_q;
    assign va_fall = s2_va_q & ~s1_va_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_va_q  <= 1'b0;
            s1_rgb_q <= '0;
            s2_vs_q  <= 1'b0;
            s2_va_q  <= 1'b0;
        end else begin
            s1_hs_q  <= bus.vga_hsync;
            s1_vs_q  <= bus.vga_vsync;
            s1_va_q  <= bus.vga_valid;
            s1_rgb_q <= {bus.vga_r, bus.vga_g, bus.vga_b};
            s2_vs_q  <= s1_vs_q;
            s2_va_q  <= s1_va_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.arm) state_d = ARMED;
            ARMED:   if (vs_fall) state_d = FRAME;
            FRAME:   if (vs_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arm_take = 1'b0;
        in_frame = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            IDLE: begin
                arm_take = bus.arm;
                busy     = 1'b0;
            end
            ARMED:   busy = 1'b1;
            FRAME:   in_frame = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // s1 pixel's coordinate is (x_q, y_q); pixels during vsync are never stored
    assign in_win = s1_va_q && s1_vs_q && (x_q >= X_LO) && (x_q < X_HI)
                    && (y_q >= Y_LO) && (y_q < Y_HI);
    assign wr_req = in_frame && in_win && (wcnt_q != NPIX);

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        line_d    = line_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        wr_en_d   = wr_req;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = in_frame && vs_fall;

        if (s1_va_q && (x_q != '1)) x_d = x_q + 1'b1;
        if (va_fall) begin
            pix_d = x_q;
            x_d   = '0;
            if (y_q != '1) y_d = y_q + 1'b1;
        end
        // frame start overrides any line-end update landing on the same cycle
        if (vs_fall) begin
            x_d = '0;
            y_d = '0;
        end

        if (arm_take) begin
            err_d  = 1'b0;
            line_d = '0;
            wcnt_d = '0;
        end

        if (wr_req) begin
            wcnt_d    = wcnt_q + 1'b1;
            wr_addr_d = wcnt_q;
            wr_data_d = s1_rgb_q;
        end

        if (in_frame) begin
            if (s1_va_q && (!s1_vs_q || !s1_hs_q)) err_d = 1'b1;
            if (va_fall && (x_q != H_EXP))         err_d = 1'b1;
            if (vs_fall) begin
                line_d = y_q;
                if ((wcnt_q != NPIX) || (y_q != V_EXP)) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            line_q    <= '0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pix_cnt  = pix_q;
    assign bus.line_cnt = line_q;
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing/picture path: samples a pixel-clock VGA stream (hsync, vsync, blank_n, RGB) and rebuilds pixel coordinates.
- On an arm request, writes one rectangular window of one full frame into an external picture RAM (row-major, same layout as the 100x100 picture ROM).
- Measures the frame geometry and flags mismatches against the expected HSIZE/VSIZE.
- Used for loopback checking of the display path and for frame grabbing.

Parameters:
- HSIZE, 640: expected active pixels per line.
- VSIZE, 480: expected active lines per frame.
- WIN_X, 270: first captured column.
- WIN_Y, 190: first captured row.
- WIN_W, 100: window width.
- WIN_H, 100: window height.
- AW, $clog2(WIN_W*WIN_H): derived write-address width.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  capture request pulse; honoured only in IDLE.
- vga_hsync  in  1  horizontal sync, active-low.
- vga_vsync  in  1  vertical sync, active-low.
- vga_valid  in  1  blank_n; 1 = active pixel.
- vga_r, vga_g, vga_b  in  8 each  pixel colour.
- wr_en  out  1  picture-RAM write strobe.
- wr_addr  out  AW  write address, row-major within the window.
- wr_data  out  24  {r,g,b}.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse at capture end.
- err  out  1  geometry error of the last capture; valid from done until next arm.
- pix_cnt  out  $clog2(HSIZE+1)  length of the last complete line.
- line_cnt  out  $clog2(VSIZE+1)  active lines counted in the last captured frame.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, all counters and input registers 0. Reset asserted mid-capture aborts immediately. No done pulse is issued for the aborted capture.
- Input stage: all VGA inputs are registered once (s1). Edges are detected on s1 against a second register (s2).
  - vsync fall = s2.vsync=1, s1.vsync=0.
  - valid fall = s2.valid=1, s1.valid=0.
- Coordinates:
  - x increments on each s1 valid cycle and saturates at all-ones.
  - On valid fall: pix_cnt <= x, x <= 0, y <= y+1 (saturating).
  - On vsync fall: y <= 0, x <= 0.
  - A pixel's coordinate is the x/y value before its own increment.
- Pixels with s1.vsync=0 are discarded. Such a pixel sets err if the FSM is in FRAME.
- FSM:
  - IDLE: arm=1 -> ARMED next cycle. On the arm edge: err, line_cnt and the write counter clear to 0.
  - ARMED: waits for vsync fall -> FRAME. A vsync fall detected in the same cycle the FSM enters ARMED is not used.
  - FRAME: for each s1 valid pixel with WIN_X <= x < WIN_X+WIN_W and WIN_Y <= y < WIN_Y+WIN_H:
    - next cycle wr_en=1, wr_data={r,g,b}, wr_addr = write counter; counter then increments.
    - Total latency: 2 clk from pins to wr_en.
    - Address is generated by counter only (no multiplier) and stops at WIN_W*WIN_H; it never wraps.
  - FRAME, next vsync fall -> IDLE with done=1 for one cycle. line_cnt = y at that edge. Set err if any of:
    - write count != WIN_W*WIN_H;
    - y != VSIZE;
    - any valid fall during FRAME with x != HSIZE.
- arm while busy is ignored (no queueing).
- wr_en is never high outside FRAME.
- busy = (FSM != IDLE).
- done and wr_en are never high in the same cycle.
- hsync is used only as a sanity check: a valid pixel with s1.hsync=0 sets err while in FRAME.

Test Plan:
- Nominal: 640x480 stream, pixel = {x[7:0], y[7:0], 8'h5A}, arm during vertical blank.
  - Exactly 10000 wr_en pulses.
  - addr 0 = 24'h0EBE5A (x=270, y=190); addr 9999 = 24'h71215A (x=369, y=289).
  - Addresses strictly consecutive.
  - done at the following vsync fall, err=0, line_cnt=480, pix_cnt=640.
- Arm mid-frame (line 300): no writes until the next vsync fall; the full next frame then captures as in the nominal case.
- Short frame with 479 lines: done=1, err=1, line_cnt=479, write count 10000.
- One 641-pixel line inside the captured frame: err=1, pix_cnt=641 after that line; capture data otherwise correct.
- rst low for 1 cycle at write 5000: wr_en, busy and done drop asynchronously. No done follows. A fresh arm gives a clean nominal capture starting at addr 0.
- Second arm pulse while busy, plus arm on the cycle of a vsync fall: the second arm is ignored and exactly one done is seen. The first arm captures the frame that starts at the next vsync fall.
